// File: rtl/tblink_rpc_rvarb_pkg.sv
// tblink_rpc_rvarb_pkg: packet sequencing states and byte width shared by the rv arbiter and address demux
//   pkt_state_e : IDLE=00, HDR=01, CNT=10, DATA=11
//   DW          : link byte width
package tblink_rpc_rvarb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_CNT  = 2'b10,
    ST_DATA = 2'b11
  } pkt_state_e;
  localparam int DW = 8;
endpackage

// File: rtl/tblink_rpc_pkt_tracker.sv
// tblink_rpc_pkt_tracker: follows header/count/payload framing of one packet on a ready/valid link
//   clock, reset : posedge clock, sync active-high reset
//   i_start      : leave IDLE and expect a header
//   i_xfer       : a byte handshake on the tracked link
//   i_dat        : byte on the tracked link (captured as count in CNT)
//   o_state      : current framing state
//   o_last_byte  : the byte now offered is the final payload byte
module tblink_rpc_pkt_tracker
  import tblink_rpc_rvarb_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_xfer,
  input  logic [DW-1:0] i_dat,
  output pkt_state_e    o_state,
  output logic          o_last_byte
);
  pkt_state_e    r_state;
  logic [DW-1:0] r_count;
  // count is tested before decrementing, so 0xFF yields 256 payload bytes with no wrap
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else
      case (r_state)
        ST_IDLE: if (i_start) r_state <= ST_HDR;
        ST_HDR:  if (i_xfer) r_state <= ST_CNT;
        ST_CNT:  if (i_xfer) begin
          r_count <= i_dat;
          r_state <= ST_DATA;
        end
        ST_DATA: if (i_xfer) begin
          if (r_count == '0) r_state <= ST_IDLE;
          else r_count <= r_count - 1'b1;
        end
      endcase
  assign o_state     = r_state;
  assign o_last_byte = (r_state == ST_DATA) && (r_count == '0);
endmodule

// File: rtl/tblink_rpc_rvarb.sv
// tblink_rpc_rvarb: packet-atomic two-source arbiter onto one 8-bit ready/valid link
//   FAIR           : 1 = round-robin, 0 = fixed priority to A
//   clock, reset   : posedge clock, sync active-high reset
//   ia_* / ib_*    : source A / B byte streams (dat, valid in; ready out)
//   o_*            : network link (dat, valid out; ready in)
//   busy           : a packet is in flight
//   sel_b          : current/last grant, 0 = A, 1 = B
module tblink_rpc_rvarb
  import tblink_rpc_rvarb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] ia_dat,
  input  logic          ia_valid,
  output logic          ia_ready,
  input  logic [DW-1:0] ib_dat,
  input  logic          ib_valid,
  output logic          ib_ready,
  output logic [DW-1:0] o_dat,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          busy,
  output logic          sel_b
);
  pkt_state_e w_state;
  logic       w_last_byte, w_active, w_start, w_xfer, w_grant_b;
  logic       r_sel_b, r_last_b;
  assign w_active  = w_state != ST_IDLE;
  assign w_start   = !w_active && (ia_valid || ib_valid);
  // with both requesting, round-robin hands the grant to whoever was not served last
  assign w_grant_b = FAIR ? ((ia_valid && ib_valid) ? !r_last_b : ib_valid) : !ia_valid;
  assign o_dat     = r_sel_b ? ib_dat : ia_dat;
  assign o_valid   = w_active && (r_sel_b ? ib_valid : ia_valid);
  assign ia_ready  = w_active && !r_sel_b && o_ready;
  assign ib_ready  = w_active && r_sel_b && o_ready;
  assign w_xfer    = o_valid && o_ready;
  assign busy      = w_active;
  assign sel_b     = r_sel_b;
  // last_b resets to B so the first contested grant goes to A
  always_ff @(posedge clock)
    if (reset) begin
      r_sel_b  <= 1'b0;
      r_last_b <= 1'b1;
    end else begin
      if (w_start) r_sel_b <= w_grant_b;
      if (w_xfer && w_last_byte) r_last_b <= r_sel_b;
    end
  tblink_rpc_pkt_tracker u_trk (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_start),
    .i_xfer     (w_xfer),
    .i_dat      (o_dat),
    .o_state    (w_state),
    .o_last_byte(w_last_byte)
  );
endmodule
